// File: rtl/receptor_uart_if.sv
// receptor_uart_if: serial line plus the Dato/Tick output bundle of the UART receiver.
// The master side drives the line and consumes the received bytes.
// The slave side is the receiver itself.
interface receptor_uart_if;
    logic       rx;
    logic [7:0] dato;
    logic       tick;
    logic       busy;
    logic       frame_err;
    logic       parity_err;

    modport master (
        output rx,
        input  dato,
        input  tick,
        input  busy,
        input  frame_err,
        input  parity_err
    );

    modport slave (
        input  rx,
        output dato,
        output tick,
        output busy,
        output frame_err,
        output parity_err
    );
endinterface

// File: rtl/receptor_uart.sv
// receptor_uart: asynchronous serial receiver with 16x oversampling.
// Default frame: 8 data bits, LSB first, 1 stop bit.
// Each good byte is presented on dato with a one-cycle tick strobe.
// Malformed frames raise frame_err (or parity_err) instead of tick.
// Optional feature macro: UART_RX_PARITY_EN. When it is defined, an even-parity
// bit sits between bit 7 and the stop bit. When it is undefined, parity_err is tied low.
module receptor_uart #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 9600,
    parameter int DIV      = CLK_FREQ / (BAUD * 16)
) (
    input  logic           clk,
    input  logic           rst,
    receptor_uart_if.slave bus
);
    localparam int               CNT_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } state_t;

    logic             rx_meta_q;
    logic             rxs_q;
    logic [CNT_W-1:0] div_q;
    logic             s_tick;

    state_t     state_q, state_d;
    logic [3:0] s_q, s_d;
    logic [2:0] n_q, n_d;
    logic [7:0] b_q, b_d;
    logic [7:0] dato_q, dato_d;
    logic       tick_q, tick_d;
    logic       ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
    logic       par_q, par_d;
    logic       perr_q, perr_d;
`endif

    // Two-flop synchronizer. It resets to the idle (high) line level so that
    // reset release cannot look like a start edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
        end else begin
            rx_meta_q <= bus.rx;
            rxs_q     <= rx_meta_q;
        end
    end

    // Free-running oversample divider. s_tick is high for one clk on the last count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q <= '0;
        end else if (div_q == DIV_LAST) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + CNT_W'(1);
        end
    end

    assign s_tick = (div_q == DIV_LAST);

    // Frame state, counters, shift register and registered output strobes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            s_q     <= 4'd0;
            n_q     <= 3'd0;
            b_q     <= 8'h00;
            dato_q  <= 8'h00;
            tick_q  <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
            dato_q  <= dato_d;
            tick_q  <= tick_d;
            ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
            par_q   <= par_d;
            perr_q  <= perr_d;
`endif
        end
    end

    // Next-state logic: walk the frame in s_tick steps. Bits are sampled at mid-bit.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        dato_d  = dato_q;
        tick_d  = 1'b0;
        ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d   = par_q;
        perr_d  = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                // Start detection is immediate; the s_tick phase is not awaited.
                if (!rxs_q) begin
                    state_d = ST_START;
                    s_d     = 4'd0;
                end
            end
            ST_START: begin
                if (s_tick) begin
                    if (s_q == 4'd7) begin
                        s_d = 4'd0;
                        if (!rxs_q) begin
                            state_d = ST_DATA;
                            n_d     = 3'd0;
                        end else begin
                            // The line went high again before mid-bit: treat it as a glitch.
                            state_d = ST_IDLE;
                        end
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
            ST_DATA: begin
                if (s_tick) begin
                    if (s_q == 4'd15) begin
                        b_d = {rxs_q, b_q[7:1]};
                        s_d = 4'd0;
                        if (n_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_d = ST_PARITY;
`else
                            state_d = ST_STOP;
`endif
                        end else begin
                            n_d = n_q + 3'd1;
                        end
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (s_tick) begin
                    if (s_q == 4'd15) begin
                        par_d   = rxs_q;
                        s_d     = 4'd0;
                        state_d = ST_STOP;
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
`endif
            ST_STOP: begin
                if (s_tick) begin
                    if (s_q == 4'd15) begin
                        state_d = ST_IDLE;
                        s_d     = 4'd0;
                        // A low stop bit wins over any parity fault.
                        if (!rxs_q) begin
                            ferr_d = 1'b1;
`ifdef UART_RX_PARITY_EN
                        end else if (par_q != (^b_q)) begin
                            perr_d = 1'b1;
`endif
                        end else begin
                            dato_d = b_q;
                            tick_d = 1'b1;
                        end
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                s_d     = 4'd0;
            end
        endcase
    end

    assign bus.dato      = dato_q;
    assign bus.tick      = tick_q;
    assign bus.frame_err = ferr_q;
    assign bus.busy      = (state_q != ST_IDLE);
`ifdef UART_RX_PARITY_EN
    assign bus.parity_err = perr_q;
`else
    assign bus.parity_err = 1'b0;
`endif

endmodule
